// File: rtl/vga_sync_monitor.sv
// Purpose: measures h/v sync timing from an upstream VGA generator, tracks lock, flags timing/blanking errors.
// Latency: every measurement and flag is visible one clk after the sync edge/sample that produced it.
// Backpressure: none; observes a free-running sync stream every cycle and cannot stall the source.
//
// Ports:
//   clk, rst                  pixel clock, asynchronous active-high reset
//   h_sync_pulse/v_sync_pulse generator sync outputs (polarity set by SYNC_ACTIVE_LOW)
//   R, G, B                   generator colour, must be 0 while either sync is active
//   err_clr                   one-cycle pulse clearing the sticky error flags
//   h_period/h_width          clocks between h leading edges / clocks of h active
//   v_lines/v_width           lines between v leading edges / lines with v active
//   locked                    timing matched the nominal raster for a full frame
//   err_h/err_v/blank_err     sticky error flags
//   frame_count               v leading edges seen while locked (wraps)
module vga_sync_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int H_PULSE         = 96,
    parameter int V_TOTAL         = 525,
    parameter int V_PULSE         = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_sync_pulse,
    input  logic        v_sync_pulse,
    input  logic [1:0]  R,
    input  logic [1:0]  G,
    input  logic [1:0]  B,
    input  logic        err_clr,
    output logic [11:0] h_period,
    output logic [11:0] h_width,
    output logic [10:0] v_lines,
    output logic [10:0] v_width,
    output logic        locked,
    output logic        err_h,
    output logic        err_v,
    output logic        blank_err,
    output logic [15:0] frame_count
);

    localparam logic        POL       = (SYNC_ACTIVE_LOW != 0);
    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [11:0] H_PULSE_W = 12'(H_PULSE);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] V_PULSE_W = 11'(V_PULSE);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t      state_q;
    logic        locked_q;
    logic        err_h_q, err_v_q, blank_err_q;
    logic [15:0] frame_count_q;

    // Previous samples hold "active" rather than the raw pin, so a reset value of 0 is the inactive level.
    logic        h_prev_q, v_prev_q;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] hw_cnt_q, hw_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic [10:0] vw_cnt_q, vw_cnt_d;
    logic [11:0] h_period_q, h_period_d;
    logic [11:0] h_width_q, h_width_d;
    logic [10:0] v_lines_q, v_lines_d;
    logic [10:0] v_width_q, v_width_d;
    // Set once an h_period has been latched since reset / since entering MEASURE; that first one is unchecked.
    logic        h_seen_q, h_seen_d;
    logic        frame_bad_q, frame_bad_d;

    logic h_act, v_act;
    logic h_lead, h_trail, v_lead, v_trail;
    logic h_bad, v_ok, frame_bad_now;
    logic go_measure, go_locked;
    logic in_locked;
    logic set_err_h, set_err_v, set_blank;

    assign h_act   = h_sync_pulse ^ POL;
    assign v_act   = v_sync_pulse ^ POL;
    assign h_lead  = h_act & ~h_prev_q;
    assign h_trail = ~h_act & h_prev_q;
    assign v_lead  = v_act & ~v_prev_q;
    assign v_trail = ~v_act & v_prev_q;

    // A measurement is judged in the cycle it latches, using the count about to be captured.
    assign h_bad = (h_lead & h_seen_q & (h_cnt_q != H_TOTAL_W))
                 | (h_trail & (hw_cnt_q != H_PULSE_W));
    // line_cnt_q still holds the closing frame's count at the v leading edge.
    assign v_ok  = (line_cnt_q == V_TOTAL_W) && (v_width_q == V_PULSE_W);
    // An h measurement latching on the v edge itself describes the frame that is closing.
    assign frame_bad_now = frame_bad_q | h_bad;

    assign in_locked = (state_q == ST_LOCKED);
    assign set_err_h = in_locked & h_bad;
    assign set_err_v = in_locked & v_lead & ~v_ok;
    assign set_blank = (|{R, G, B}) & (h_act | v_act);

    always_comb begin
        go_measure = 1'b0;
        go_locked  = 1'b0;
        case (state_q)
            ST_SEARCH:  go_measure = v_lead;
            ST_MEASURE: go_locked  = v_lead & ~frame_bad_now & v_ok;
            ST_LOCKED:  go_measure = h_bad | (v_lead & (frame_bad_now | ~v_ok));
            default:    go_measure = 1'b1;
        endcase
    end

    always_comb begin
        h_cnt_d    = (h_cnt_q == 12'hFFF) ? h_cnt_q : h_cnt_q + 12'd1;
        h_period_d = h_period_q;
        if (h_lead) begin
            h_period_d = h_cnt_q;
            h_cnt_d    = 12'd1;
        end

        hw_cnt_d  = hw_cnt_q;
        h_width_d = h_width_q;
        if (h_trail) begin
            h_width_d = hw_cnt_q;
            hw_cnt_d  = 12'd0;
        end else if (h_act && hw_cnt_q != 12'hFFF) begin
            hw_cnt_d = hw_cnt_q + 12'd1;
        end

        // The h edge coincident with a v leading edge starts the new frame's line count.
        line_cnt_d = line_cnt_q;
        v_lines_d  = v_lines_q;
        if (v_lead) begin
            v_lines_d  = line_cnt_q;
            line_cnt_d = {10'd0, h_lead};
        end else if (h_lead && line_cnt_q != 11'h7FF) begin
            line_cnt_d = line_cnt_q + 11'd1;
        end

        vw_cnt_d  = vw_cnt_q;
        v_width_d = v_width_q;
        if (v_lead) begin
            vw_cnt_d = {10'd0, h_lead};
        end else if (v_trail) begin
            v_width_d = vw_cnt_q;
            vw_cnt_d  = 11'd0;
        end else if (v_act && h_lead && vw_cnt_q != 11'h7FF) begin
            vw_cnt_d = vw_cnt_q + 11'd1;
        end

        h_seen_d = h_seen_q | h_lead;
        if (go_measure) begin
            h_seen_d = 1'b0;
        end

        frame_bad_d = v_lead ? 1'b0 : frame_bad_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_prev_q    <= 1'b0;
            v_prev_q    <= 1'b0;
            h_cnt_q     <= '0;
            hw_cnt_q    <= '0;
            line_cnt_q  <= '0;
            vw_cnt_q    <= '0;
            h_period_q  <= '0;
            h_width_q   <= '0;
            v_lines_q   <= '0;
            v_width_q   <= '0;
            h_seen_q    <= 1'b0;
            frame_bad_q <= 1'b0;
        end else begin
            h_prev_q    <= h_act;
            v_prev_q    <= v_act;
            h_cnt_q     <= h_cnt_d;
            hw_cnt_q    <= hw_cnt_d;
            line_cnt_q  <= line_cnt_d;
            vw_cnt_q    <= vw_cnt_d;
            h_period_q  <= h_period_d;
            h_width_q   <= h_width_d;
            v_lines_q   <= v_lines_d;
            v_width_q   <= v_width_d;
            h_seen_q    <= h_seen_d;
            frame_bad_q <= frame_bad_d;
        end
    end

    // Lock FSM with registered status outputs; a same-cycle set beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SEARCH;
            locked_q      <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
            blank_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (go_measure) begin
                state_q  <= ST_MEASURE;
                locked_q <= 1'b0;
            end else if (go_locked) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
            end
            err_h_q     <= set_err_h | (err_h_q & ~err_clr);
            err_v_q     <= set_err_v | (err_v_q & ~err_clr);
            blank_err_q <= set_blank | (blank_err_q & ~err_clr);
            // Counts the edge that leaves LOCKED too, since the frame just ended was a locked one.
            if (in_locked && v_lead) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign h_period    = h_period_q;
    assign h_width     = h_width_q;
    assign v_lines     = v_lines_q;
    assign v_width     = v_width_q;
    assign locked      = locked_q;
    assign err_h       = err_h_q;
    assign err_v       = err_v_q;
    assign blank_err   = blank_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Purpose: drives a scaled-down raster into vga_sync_monitor and compares every output with a timestamp-based model.
// Latency: outputs are compared 1 time unit after the clock edge that consumed each stimulus cycle.
// Backpressure: none; the bench owns the sync stream and never waits on the DUT.
module tb_vga_sync_monitor;

    localparam int   HT  = 40;
    localparam int   HP  = 6;
    localparam int   VT  = 12;
    localparam int   VP  = 2;
    localparam logic POL = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_sync_pulse, v_sync_pulse, err_clr;
    logic [1:0]  R, G, B;
    logic [11:0] h_period, h_width;
    logic [10:0] v_lines, v_width;
    logic        locked, err_h, err_v, blank_err;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_PULSE(HP), .V_TOTAL(VT), .V_PULSE(VP), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst),
        .h_sync_pulse(h_sync_pulse), .v_sync_pulse(v_sync_pulse),
        .R(R), .G(G), .B(B), .err_clr(err_clr),
        .h_period(h_period), .h_width(h_width), .v_lines(v_lines), .v_width(v_width),
        .locked(locked), .err_h(err_h), .err_v(err_v), .blank_err(blank_err),
        .frame_count(frame_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: counters kept as timestamps of the last edges, lock kept as a mode name.
    localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;
    int   m_k, m_t_hlead, m_lines, m_vw, m_mode;
    logic m_ph, m_pv, m_fbad, m_first_unchecked, m_evt;
    int   e_hp, e_hw, e_vl, e_vw, e_fc;
    logic e_errh, e_errv, e_blank;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        m_k = 0; m_t_hlead = 0; m_lines = 0; m_vw = 0; m_mode = M_SEARCH;
        m_ph = 1'b0; m_pv = 1'b0; m_fbad = 1'b0; m_first_unchecked = 1'b1;
        e_hp = 0; e_hw = 0; e_vl = 0; e_vw = 0; e_fc = 0;
        e_errh = 1'b0; e_errv = 1'b0; e_blank = 1'b0;
    endtask

    task automatic model_step(input logic ha, input logic va, input logic [5:0] rgb, input logic clr);
        logic hl, ht, vl, vt, hb, v_ok, enter, seth, setv, setb;
        int   per, wid, old_lines, old_vw;
        hl = ha && !m_ph;  ht = !ha && m_ph;
        vl = va && !m_pv;  vt = !va && m_pv;
        hb = 1'b0;
        old_lines = m_lines;
        old_vw    = e_vw;
        if (hl) begin
            per = sat(m_k - m_t_hlead, 4095);
            e_hp = per;
            if (!m_first_unchecked && per != HT) hb = 1'b1;
            m_first_unchecked = 1'b0;
            m_t_hlead = m_k;
        end
        if (ht) begin
            wid = sat(m_k - m_t_hlead, 4095);
            e_hw = wid;
            if (wid != HP) hb = 1'b1;
        end
        if (vl) begin
            e_vl = old_lines;
            m_lines = hl ? 1 : 0;
            m_vw    = hl ? 1 : 0;
        end else begin
            if (hl) m_lines = sat(m_lines + 1, 2047);
            if (va && hl) m_vw = sat(m_vw + 1, 2047);
        end
        if (vt) begin
            e_vw = m_vw;
            m_vw = 0;
        end
        v_ok  = (old_lines == VT) && (old_vw == VP);
        enter = 1'b0;
        seth  = 1'b0;
        setv  = 1'b0;
        if (m_mode == M_SEARCH) begin
            if (vl) begin m_mode = M_MEASURE; enter = 1'b1; end
        end else if (m_mode == M_MEASURE) begin
            if (vl && !(m_fbad || hb) && v_ok) m_mode = M_LOCKED;
        end else begin
            if (vl) e_fc = (e_fc + 1) % 65536;
            seth = hb;
            setv = vl && !v_ok;
            if (hb || (vl && (m_fbad || hb || !v_ok))) begin m_mode = M_MEASURE; enter = 1'b1; end
        end
        if (enter) m_first_unchecked = 1'b1;
        m_fbad  = vl ? 1'b0 : (m_fbad || hb);
        setb    = (rgb != 6'd0) && (ha || va);
        e_errh  = seth || (e_errh && !clr);
        e_errv  = setv || (e_errv && !clr);
        e_blank = setb || (e_blank && !clr);
        m_evt   = hl || ht || vl || vt || clr || setb;
        m_ph = ha;
        m_pv = va;
        m_k++;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".h_period"},    32'(h_period),    32'(e_hp));
        check_val({tag, ".h_width"},     32'(h_width),     32'(e_hw));
        check_val({tag, ".v_lines"},     32'(v_lines),     32'(e_vl));
        check_val({tag, ".v_width"},     32'(v_width),     32'(e_vw));
        check_val({tag, ".locked"},      32'(locked),      32'(m_mode == M_LOCKED));
        check_val({tag, ".err_h"},       32'(err_h),       32'(e_errh));
        check_val({tag, ".err_v"},       32'(err_v),       32'(e_errv));
        check_val({tag, ".blank_err"},   32'(blank_err),   32'(e_blank));
        check_val({tag, ".frame_count"}, 32'(frame_count), 32'(e_fc));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".h_period"},    32'(h_period),    32'd0);
        check_val({tag, ".h_width"},     32'(h_width),     32'd0);
        check_val({tag, ".v_lines"},     32'(v_lines),     32'd0);
        check_val({tag, ".v_width"},     32'(v_width),     32'd0);
        check_val({tag, ".locked"},      32'(locked),      32'd0);
        check_val({tag, ".err_h"},       32'(err_h),       32'd0);
        check_val({tag, ".err_v"},       32'(err_v),       32'd0);
        check_val({tag, ".blank_err"},   32'(blank_err),   32'd0);
        check_val({tag, ".frame_count"}, 32'(frame_count), 32'd0);
    endtask

    logic       rand_en = 1'b0;
    logic       inj_clr = 1'b0;
    logic [5:0] inj_rgb = 6'd0;

    task automatic step(input logic ha, input logic va, input logic [5:0] rgb_in);
        logic       clr;
        logic [5:0] rgb;
        clr = inj_clr;
        inj_clr = 1'b0;
        rgb = rgb_in;
        if (inj_rgb != 6'd0) begin
            rgb = inj_rgb;
            inj_rgb = 6'd0;
        end
        if (rand_en && $urandom_range(0, 299) == 0) clr = 1'b1;
        h_sync_pulse = ha ^ POL;
        v_sync_pulse = va ^ POL;
        {R, G, B} = rgb;
        err_clr = clr;
        @(posedge clk);
        #1;
        model_step(ha, va, rgb, clr);
        if (m_evt) check_all("cyc");
    endtask

    task automatic line_part(input logic va, input int len, input int hw, input int from, input int to);
        for (int c = from; c < to && c < len; c++) begin
            logic       ha;
            logic [5:0] rgb;
            ha = (c < hw);
            if (ha || va)
                rgb = (rand_en && $urandom_range(0, 399) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            else
                rgb = 6'($urandom);
            step(ha, va, rgb);
        end
    endtask

    task automatic run_lines(input int from, input int to, input int long_line);
        for (int l = from; l < to; l++) begin
            int len, hw;
            len = (l == long_line) ? HT + 1 : HT;
            hw  = (rand_en && $urandom_range(0, 59) == 0) ? HP + 1 : HP;
            line_part(l < VP, len, hw, 0, len);
        end
    endtask

    int fc_exp;

    initial begin
        rst = 1'b1;
        h_sync_pulse = POL; v_sync_pulse = POL;
        R = 2'd0; G = 2'd0; B = 2'd0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Nominal raster: first v edge enters MEASURE, second locks, third counts a frame.
        run_lines(0, VT, -1);
        check_val("nom.unlocked_after_1st", 32'(locked), 32'd0);
        line_part(1'b1, HT, HP, 0, 1);
        check_val("nom.locked_after_2nd", 32'(locked), 32'd1);
        check_val("nom.fc_after_2nd", 32'(frame_count), 32'd0);
        line_part(1'b1, HT, HP, 1, HT);
        run_lines(1, VT, -1);
        run_lines(0, VT, -1);
        check_val("nom.h_period", 32'(h_period), HT);
        check_val("nom.h_width", 32'(h_width), HP);
        check_val("nom.v_lines", 32'(v_lines), VT);
        check_val("nom.v_width", 32'(v_width), VP);
        check_val("nom.fc_after_3rd", 32'(frame_count), 32'd1);

        // One long line inside a locked frame.
        run_lines(0, 6, 5);
        line_part(1'b0, HT, HP, 0, 1);
        check_val("long.h_period", 32'(h_period), HT + 1);
        check_val("long.locked", 32'(locked), 32'd0);
        check_val("long.err_h", 32'(err_h), 32'd1);
        line_part(1'b0, HT, HP, 1, HT);
        run_lines(7, VT, -1);
        line_part(1'b1, HT, HP, 0, 1);
        check_val("long.still_unlocked", 32'(locked), 32'd0);
        line_part(1'b1, HT, HP, 1, HT);
        run_lines(1, VT, -1);
        line_part(1'b1, HT, HP, 0, 1);
        check_val("long.relocked", 32'(locked), 32'd1);
        check_val("long.err_h_sticky", 32'(err_h), 32'd1);
        line_part(1'b1, HT, HP, 1, HT);
        run_lines(1, VT, -1);

        // err_clr and blanking violations inside h sync.
        run_lines(0, 3, -1);
        line_part(1'b0, HT, HP, 0, 1);
        inj_clr = 1'b1;
        line_part(1'b0, HT, HP, 1, 2);
        check_val("clr.err_h", 32'(err_h), 32'd0);
        inj_rgb = 6'b01_00_00;
        line_part(1'b0, HT, HP, 2, 3);
        check_val("blank.set", 32'(blank_err), 32'd1);
        inj_clr = 1'b1;
        line_part(1'b0, HT, HP, 3, 4);
        check_val("blank.cleared", 32'(blank_err), 32'd0);
        inj_clr = 1'b1;
        inj_rgb = 6'b01_00_00;
        line_part(1'b0, HT, HP, 4, 5);
        check_val("blank.set_wins", 32'(blank_err), 32'd1);
        line_part(1'b0, HT, HP, 5, HT);
        run_lines(4, VT, -1);

        // Short frame while locked.
        run_lines(0, VT - 1, -1);
        fc_exp = e_fc + 1;
        line_part(1'b1, HT, HP, 0, 1);
        check_val("short.v_lines", 32'(v_lines), VT - 1);
        check_val("short.err_v", 32'(err_v), 32'd1);
        check_val("short.locked", 32'(locked), 32'd0);
        check_val("short.frame_count", 32'(frame_count), 32'(fc_exp));
        line_part(1'b1, HT, HP, 1, HT);
        run_lines(1, VT, -1);
        run_lines(0, VT, -1);

        // Asynchronous reset mid-line while locked.
        run_lines(0, 3, -1);
        line_part(1'b0, HT, HP, 0, 20);
        check_val("arst.pre_locked", 32'(locked), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("arst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        line_part(1'b0, HT, HP, 20, HT);
        run_lines(4, VT, -1);
        line_part(1'b1, HT, HP, 0, 1);
        check_val("arst.locked", 32'(locked), 32'd0);
        check_val("arst.err_h", 32'(err_h), 32'd0);
        check_val("arst.err_v", 32'(err_v), 32'd0);
        line_part(1'b1, HT, HP, 1, HT);
        run_lines(1, VT, -1);
        run_lines(0, VT, -1);

        // h_sync idle long enough to saturate the clock counter.
        for (int i = 0; i < 5000; i++) step(1'b0, 1'b0, 6'($urandom));
        step(1'b1, 1'b0, 6'd0);
        check_val("sat.h_period", 32'(h_period), 32'd4095);
        line_part(1'b0, HT, HP, 1, HT);

        // Randomised frames: odd line counts, long lines, wide pulses, colour violations, err_clr.
        rand_en = 1'b1;
        for (int f = 0; f < 12; f++) begin
            int nl, ll;
            nl = ($urandom_range(0, 3) == 0) ? VT + 2 * int'($urandom_range(0, 1)) - 1 : VT;
            ll = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            run_lines(0, nl, ll);
        end
        rand_en = 1'b0;
        run_lines(0, VT, -1);
        run_lines(0, VT, -1);
        line_part(1'b1, HT, HP, 0, 1);
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters SHALL be: H_TOTAL, 800, clocks per line; H_PULSE, 96, h sync width in clocks; V_TOTAL, 525, lines per frame; V_PULSE, 2, v sync width in lines; SYNC_ACTIVE_LOW, 1, sync polarity (1 = active when input is 0).
REQ-002 Port clk SHALL be an input, 1 bit: the pixel clock, rising-edge active, the same clock that drives the upstream sync generator.
REQ-003 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-004 Inputs SHALL be h_sync_pulse and v_sync_pulse (1 bit each, the sync outputs of the upstream generator) and R, G, B (2 bits each, generator colour).
REQ-005 Input err_clr SHALL be 1 bit: a single-cycle pulse that clears the sticky error flags.
REQ-006 Outputs SHALL be: h_period (12 bits, clocks between h leading edges); h_width (12 bits, h active clocks); v_lines (11 bits, lines between v leading edges); v_width (11 bits, lines with v active).
REQ-007 Further outputs SHALL be: locked (1 bit); err_h, err_v, blank_err (1 bit each, sticky); frame_count (16 bits).

Function
REQ-008 Inputs SHALL be treated as synchronous to clk, with no synchronizers; active(x) = x XOR SYNC_ACTIVE_LOW.
REQ-009 Edge detect: prev registers SHALL hold the last samples, and the reset value of each SHALL be the inactive level; a leading edge = active now and prev inactive; a trailing edge = inactive now and prev active.
REQ-010 Clock counter h_cnt SHALL increment every cycle, saturating at 4095; on an h leading edge, h_period <= h_cnt and h_cnt <= 1, visible one cycle after the edge clock.
REQ-011 Width counter SHALL increment while h is active, saturating at 4095; on an h trailing edge, h_width <= count and the count clears.
REQ-012 line_cnt SHALL increment on each h leading edge, saturating at 2047; on a v leading edge, v_lines <= line_cnt and line_cnt <= 1 if an h leading edge coincides, else 0 (a coincident h edge belongs to the new frame).
REQ-013 v_width SHALL count h leading edges while v is active, including an h edge coincident with the v leading edge, and SHALL latch on the v trailing edge.
REQ-014 Per-frame flag frame_bad SHALL set on any h_period != H_TOTAL or h_width != H_PULSE latched during the frame; it SHALL clear at each v leading edge after evaluation.
REQ-015 The first h_period after reset and the first h_period after entering MEASURE SHALL be excluded from checks.
REQ-016 The FSM SHALL have states SEARCH, MEASURE and LOCKED, with SEARCH as the reset state.
REQ-017 SEARCH SHALL go to MEASURE on the first v leading edge.
REQ-018 MEASURE SHALL go to LOCKED on a v leading edge when !frame_bad and line_cnt == V_TOTAL and the v_width latched in that frame == V_PULSE; otherwise it SHALL stay in MEASURE.
REQ-019 LOCKED SHALL go to MEASURE on the first bad h measurement (same cycle the value latches) or on a bad frame at a v edge.
REQ-020 locked SHALL be 1 only in LOCKED.
REQ-021 err_h SHALL set on an h mismatch while LOCKED; err_v SHALL set on a v_lines/v_width mismatch while LOCKED.
REQ-022 blank_err SHALL set in any state when R|G|B != 0 while h or v is active.
REQ-023 err_clr SHALL clear all sticky flags; a set condition in the same cycle SHALL win.
REQ-024 frame_count SHALL increment on each v leading edge while LOCKED (including the edge that leaves LOCKED) and SHALL wrap at 65535.

Reset
REQ-025 On rst assertion, regardless of clk, the block SHALL set all counters, measurements, frame_count and flags to 0, locked to 0, and the FSM to SEARCH.
REQ-026 Reset mid-frame SHALL discard partial measurements.
REQ-027 After deassertion, the first measurement SHALL follow REQ-015.

Verification
REQ-028 Nominal: 800x525 timing, widths 96/2, RGB 0 in sync -> h_period=800, h_width=96, v_lines=525, v_width=2; locked=1 after the 2nd v edge; frame_count=1 after the 3rd.
REQ-029 One line of 801 clocks in a locked frame -> h_period=801; locked drops the next cycle; err_h=1; relocks after one clean frame; err_h stays 1 until err_clr.
REQ-030 R=2'b01 for one clock during h sync -> blank_err=1; err_clr pulse with no new violation -> 0; err_clr coincident with a violation -> stays 1.
REQ-031 rst asserted mid-line while LOCKED -> all outputs 0 asynchronously; first v edge after release -> MEASURE, with no err flags set.
REQ-032 h_sync held inactive for 5000 clocks, then a leading edge -> h_period=4095 (saturated), with no wrap.
REQ-033 Frame of 524 lines while LOCKED -> v_lines=524, err_v=1, locked=0, frame_count incremented once at that edge.
